// File: rtl/return_stack_ctrl.sv
// Parametrised return-address stack: push on call, pop on return, with tail-call
// push+pop, flush, occupancy status, sticky error reporting and optional circular overwrite.
module return_stack_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int WRAP_MODE = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              Sys_Clock,
  input  logic              Reset,
  input  logic              Stack_Enable,
  input  logic              Push,
  input  logic              Pop,
  input  logic              Flush,
  input  logic              Err_Clear,
  input  logic [DATA_W-1:0] Push_Data,
  output logic [DATA_W-1:0] Ret_Add,
  output logic              Ret_Valid,
  output logic [DATA_W-1:0] Top_Data,
  output logic [CNT_W-1:0]  Count,
  output logic              Full,
  output logic              Empty,
  output logic              Err_Out,
  output logic [1:0]        Err_Code
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10
  } err_code_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp, sp_n, base, base_n, top_idx, wr_idx;
  logic [CNT_W-1:0]  count, count_n;
  logic [DATA_W-1:0] ret_add_n;
  logic              ret_valid_n, wr_en, err_out_n;
  err_code_e         err_code, err_code_n, err_event;

  // SP points at the next free slot; the top entry sits one below it.
  assign top_idx  = sp - PTR_W'(1);
  assign Count    = count;
  assign Full     = (count == CNT_W'(DEPTH));
  assign Empty    = (count == '0);
  assign Top_Data = Empty ? '0 : mem[top_idx];
  assign Err_Code = err_code;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    sp_n        = sp;
    base_n      = base;
    count_n     = count;
    ret_add_n   = Ret_Add;
    ret_valid_n = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = sp;
    err_event   = ERR_NONE;

    if (Stack_Enable) begin
      if (Flush) begin
        sp_n    = '0;
        base_n  = '0;
        count_n = '0;
      end else begin
        unique case ({Push, Pop})
          2'b10: begin
            if (!Full) begin
              wr_en   = 1'b1;
              sp_n    = sp + PTR_W'(1);
              count_n = count + CNT_W'(1);
            end else if (WRAP_MODE != 0) begin
              // Overwrite the oldest entry; the window slides forward by one.
              wr_en  = 1'b1;
              sp_n   = sp + PTR_W'(1);
              base_n = base + PTR_W'(1);
            end else begin
              err_event = ERR_OVERFLOW;
            end
          end
          2'b01: begin
            if (!Empty) begin
              sp_n        = top_idx;
              ret_add_n   = mem[top_idx];
              ret_valid_n = 1'b1;
              count_n     = count - CNT_W'(1);
            end else begin
              err_event = ERR_UNDERFLOW;
            end
          end
          2'b11: begin
            if (!Empty) begin
              // Tail call: return the old top and replace it in place.
              ret_add_n   = mem[top_idx];
              ret_valid_n = 1'b1;
              wr_en       = 1'b1;
              wr_idx      = top_idx;
            end else begin
              wr_en     = 1'b1;
              sp_n      = sp + PTR_W'(1);
              count_n   = count + CNT_W'(1);
              err_event = ERR_UNDERFLOW;
            end
          end
          default: ;
        endcase
      end
    end

    // A new error on the same edge as a clear takes precedence.
    err_out_n  = Err_Out;
    err_code_n = err_code;
    if (err_event != ERR_NONE) begin
      err_out_n  = 1'b1;
      err_code_n = err_event;
    end else if (Err_Clear) begin
      err_out_n  = 1'b0;
      err_code_n = ERR_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(negedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      sp        <= '0;
      base      <= '0;
      count     <= '0;
      Ret_Add   <= '0;
      Ret_Valid <= 1'b0;
      Err_Out   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      sp        <= sp_n;
      base      <= base_n;
      count     <= count_n;
      Ret_Add   <= ret_add_n;
      Ret_Valid <= ret_valid_n;
      Err_Out   <= err_out_n;
      err_code  <= err_code_n;
    end
  end

  // NOTE: the storage array has no reset; Count gates every read so stale contents are never visible.
  always_ff @(negedge Sys_Clock) begin
    if (wr_en) mem[wr_idx] <= Push_Data;
  end

endmodule
